// File: rtl/jtvigil_colmix.sv
// Colour mixer for the tilemap (scr1), background (scr2) and object layers.
// Each pixel, one layer is picked by priority and looked up in a CPU-writable
// palette. The result is driven out as CW-bit RGB. Blanking is delayed through
// the same three pixel-enable stages so that it stays aligned with the colour.
//
// Pipeline, advanced only on pxl_cen:
//   stage 1 : layer priority -> palette index (idx_reg)
//   stage 2 : synchronous palette read for R, G and B (vid_q_reg)
//   stage 3 : output colour register, forced to zero while blanked (col_reg)
//
// The palette is three 512-entry RAMs, one per component. Each RAM has a CPU
// port, which runs on every clk, and a video read port, which runs on pxl_cen.
module jtvigil_colmix #(
  parameter int         CW     = 5,
  parameter logic [3:0] TRANSP = 4'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          lhbl,
  input  logic          lvbl,
  input  logic [7:0]    scr1_pxl,
  input  logic [3:0]    scr2_pxl,
  input  logic [7:0]    obj_pxl,
  input  logic [2:0]    gfx_en,
  input  logic [10:0]   main_addr,
  input  logic [7:0]    main_dout,
  input  logic          main_rnw,
  input  logic          pal_cs,
  output logic [7:0]    main_din,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue,
  output logic          lhbl_dly,
  output logic          lvbl_dly
);

  // obj_pxl[7] is a priority bit that this board does not use. The upper data
  // bits are not stored because an entry is only CW bits wide.
  logic unused_inputs;
  assign unused_inputs = ^{obj_pxl[7], main_dout[7:CW]};

  // ---------------------------------------------------------------------------
  // Stage 1: layer priority
  // ---------------------------------------------------------------------------
  logic [8:0] idx_next;
  logic [8:0] idx_reg;

  // Pick the winning layer. obj is above scr1, and scr1 is above scr2.
  // scr2 is always opaque. When scr2 is disabled, the fallback entry 0x180
  // is used so that the screen shows a defined colour.
  always_comb begin
    idx_next = 9'h180;
    if (gfx_en[2] && (obj_pxl[3:0] != TRANSP)) begin
      idx_next = {2'b10, obj_pxl[6:0]};
    end else if (gfx_en[0] && (scr1_pxl[3:0] != TRANSP)) begin
      idx_next = {1'b0, scr1_pxl};
    end else if (gfx_en[1]) begin
      idx_next = {5'b11000, scr2_pxl};
    end
  end

  // Latch the palette index of the incoming pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg <= 9'd0;
    end else if (pxl_cen) begin
      idx_reg <= idx_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Blanking delay line: index 0 goes with stage 1, index 2 goes with the outputs
  // ---------------------------------------------------------------------------
  logic [2:0] hb_sr_reg;
  logic [2:0] vb_sr_reg;
  logic       blank_s2;

  // Shift the blanking signals alongside the pixel. Reset leaves them low,
  // so the output reads as blanked until three valid pixels have gone through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_sr_reg <= 3'b000;
      vb_sr_reg <= 3'b000;
    end else if (pxl_cen) begin
      hb_sr_reg <= {hb_sr_reg[1:0], lhbl};
      vb_sr_reg <= {vb_sr_reg[1:0], lvbl};
    end
  end

  // This is the blank state of the pixel that is about to enter the output register.
  assign blank_s2 = ~(hb_sr_reg[1] & vb_sr_reg[1]);
  assign lhbl_dly = hb_sr_reg[2];
  assign lvbl_dly = vb_sr_reg[2];

  // ---------------------------------------------------------------------------
  // Palette RAMs and colour stages, one copy per component (0=R, 1=G, 2=B)
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cpu_rd [0:2];
  logic [CW-1:0] col_out [0:2];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_comp
      localparam logic [1:0] COMP = 2'(gi);

      logic [CW-1:0] pal_mem [0:511];
      logic [CW-1:0] cpu_rd_reg;
      logic [CW-1:0] vid_q_reg;
      logic [CW-1:0] col_reg;
      logic          cpu_we;

      assign cpu_we = pal_cs & ~main_rnw & (main_addr[10:9] == COMP);

      // CPU port: write, then registered read-before-write. The CPU port
      // ignores pxl_cen. The palette contents are never reset.
      always_ff @(posedge clk) begin
        if (cpu_we) begin
          pal_mem[main_addr[8:0]] <= main_dout[CW-1:0];
        end
        cpu_rd_reg <= pal_mem[main_addr[8:0]];
      end

      // Stage 2: video read. If the CPU writes the same entry in the same
      // clk, this read returns the old value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vid_q_reg <= '0;
        end else if (pxl_cen) begin
          vid_q_reg <= pal_mem[idx_reg];
        end
      end

      // Stage 3: output colour register, forced to zero while blanked.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          col_reg <= '0;
        end else if (pxl_cen) begin
          col_reg <= blank_s2 ? '0 : vid_q_reg;
        end
      end

      assign cpu_rd[gi]  = cpu_rd_reg;
      assign col_out[gi] = col_reg;
    end
  endgenerate

  assign red   = col_out[0];
  assign green = col_out[1];
  assign blue  = col_out[2];

  // ---------------------------------------------------------------------------
  // CPU read-back path
  // ---------------------------------------------------------------------------
  logic [1:0] sel_reg;
  logic       din_valid_reg;

  // Remember which component was addressed, so that the registered RAM data
  // can be steered onto main_din. din_valid_reg keeps main_din at zero from
  // reset until the first read after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg       <= 2'd0;
      din_valid_reg <= 1'b0;
    end else begin
      sel_reg       <= main_addr[10:9];
      din_valid_reg <= 1'b1;
    end
  end

  // Drive main_din from the registered RAM data. Component 3 has no RAM
  // behind it, so it reads back as zero.
  always_comb begin
    main_din = 8'h00;
    if (din_valid_reg) begin
      case (sel_reg)
        2'd0:    main_din = {{(8-CW){1'b0}}, cpu_rd[0]};
        2'd1:    main_din = {{(8-CW){1'b0}}, cpu_rd[1]};
        2'd2:    main_din = {{(8-CW){1'b0}}, cpu_rd[2]};
        default: main_din = 8'h00;
      endcase
    end
  end

endmodule
